// File: rtl/ysyx_220066_mem_pkg.sv
// Shared types and constants for the ysyx_220066 memory arbiter.
// Covers FSM states, port ownership, load/store op codes and size decode.
package ysyx_220066_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_MISALIGN
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_D  = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;
    localparam logic [2:0] OP_WU = 3'b110;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef struct packed {
        owner_t      owner;
        logic        we;
        logic [2:0]  op;
        logic [63:0] addr;
        logic [63:0] wdata;
    } txn_t;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        unique case (sz)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ysyx_220066_mem_align.sv
// Byte-lane alignment for the memory arbiter: store lane shift and mask,
// load shift with sign/zero extension, and misalignment detection.
module ysyx_220066_mem_align
    import ysyx_220066_mem_pkg::*;
(
    input  logic [2:0]  chk_op,
    input  logic [2:0]  chk_off,
    output logic        misalign,
    input  logic [2:0]  op,
    input  logic [2:0]  off,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [7:0]  wmask,
    output logic [63:0] wdata_sh,
    output logic [63:0] rdata_ext
);

    logic [5:0]  sh;
    logic [63:0] rd_sh;

    assign sh       = {off, 3'b000};
    assign wmask    = size_mask(op[1:0]) << off;
    assign wdata_sh = wdata << sh;
    assign rd_sh    = rdata >> sh;

    always_comb begin
        misalign = 1'b0;
        unique case (chk_op)
            OP_H, OP_HU: misalign = chk_off[0];
            OP_W, OP_WU: misalign = |chk_off[1:0];
            OP_D:        misalign = |chk_off;
            default:     misalign = 1'b0;
        endcase
    end

    always_comb begin
        rdata_ext = rd_sh;
        unique case (op)
            OP_B:    rdata_ext = {{56{rd_sh[7]}}, rd_sh[7:0]};
            OP_H:    rdata_ext = {{48{rd_sh[15]}}, rd_sh[15:0]};
            OP_W:    rdata_ext = {{32{rd_sh[31]}}, rd_sh[31:0]};
            OP_BU:   rdata_ext = {56'b0, rd_sh[7:0]};
            OP_HU:   rdata_ext = {48'b0, rd_sh[15:0]};
            OP_WU:   rdata_ext = {32'b0, rd_sh[31:0]};
            default: rdata_ext = rd_sh;
        endcase
    end

endmodule

// File: rtl/ysyx_220066_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Data has priority; a starvation counter forces fetch in periodically.
module ysyx_220066_mem_arbiter
    import ysyx_220066_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    input  logic        if_kill,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        if_error,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [2:0]  d_op,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic [63:0] d_rdata,
    output logic        d_valid,
    output logic        d_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    input  logic        mem_err
);

    state_t      state;
    state_t      state_nx;
    txn_t        txn_q;
    logic [2:0]  starve_cnt;
    logic        kill_q;

    logic        d_req;
    logic        mis;
    logic        d_mis;
    logic        force_if;
    logic        grant_d;
    logic        grant_if;
    logic        idle;
    logic [7:0]  al_wmask;
    logic [63:0] al_wdata;
    logic [63:0] al_rdata;

    assign idle     = (state == ST_IDLE);
    assign d_req    = d_rd | d_wr;
    assign d_mis    = d_req & mis;
    assign force_if = if_req & ~if_kill
                    & (starve_cnt == 3'(STARVE_MAX));
    assign grant_d  = d_req & ~mis & ~force_if;
    assign grant_if = if_req & ~if_kill & ~d_mis
                    & (~d_req | force_if);

    ysyx_220066_mem_align u_align (
        .chk_op    (d_op),
        .chk_off   (d_addr[2:0]),
        .misalign  (mis),
        .op        (txn_q.op),
        .off       (txn_q.addr[2:0]),
        .wdata     (txn_q.wdata),
        .rdata     (mem_rdata),
        .wmask     (al_wmask),
        .wdata_sh  (al_wdata),
        .rdata_ext (al_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (d_mis)                    state_nx = ST_MISALIGN;
                else if (grant_d || grant_if) state_nx = ST_REQ;
            end
            ST_REQ:      if (mem_gnt)    state_nx = ST_WAIT;
            ST_WAIT:     if (mem_rvalid) state_nx = ST_IDLE;
            ST_MISALIGN: state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txn_q      <= '0;
            starve_cnt <= 3'd0;
            kill_q     <= 1'b0;
        end else begin
            if (idle && grant_d) begin
                txn_q <= '{owner: OWN_D, we: d_wr, op: d_op,
                           addr: d_addr, wdata: d_wdata};
            end else if (idle && grant_if) begin
                txn_q <= '{owner: OWN_IF, we: 1'b0, op: OP_WU,
                           addr: if_addr, wdata: 64'b0};
            end

            if (!if_req)
                starve_cnt <= 3'd0;
            else if (idle && grant_if)
                starve_cnt <= 3'd0;
            else if (idle && grant_d && starve_cnt != 3'h7)
                starve_cnt <= starve_cnt + 3'd1;

            // A killed fetch still finishes its bus handshake; only the
            // response to the core is dropped.
            if (state != ST_REQ && state != ST_WAIT)
                kill_q <= 1'b0;
            else if (if_kill && txn_q.owner == OWN_IF)
                kill_q <= 1'b1;
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 64'b0;
        mem_wdata = 64'b0;
        mem_wmask = 8'b0;
        if_instr  = 32'b0;
        if_valid  = 1'b0;
        if_error  = 1'b0;
        d_rdata   = 64'b0;
        d_valid   = 1'b0;
        d_error   = 1'b0;
        unique case (state)
            ST_REQ: begin
                mem_req  = 1'b1;
                mem_we   = txn_q.we;
                mem_addr = {txn_q.addr[63:3], 3'b000};
                if (txn_q.we) begin
                    mem_wmask = al_wmask;
                    mem_wdata = al_wdata;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    if (txn_q.owner == OWN_IF) begin
                        if (!kill_q && !if_kill) begin
                            if_valid = 1'b1;
                            if_error = mem_err;
                            if_instr = txn_q.addr[2] ? mem_rdata[63:32]
                                                     : mem_rdata[31:0];
                        end
                    end else begin
                        d_valid = 1'b1;
                        d_error = mem_err;
                        d_rdata = txn_q.we ? 64'b0 : al_rdata;
                    end
                end
            end
            ST_MISALIGN: begin
                d_valid = 1'b1;
                d_error = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
